// File: rtl/conv_pkg.sv
// Shared conv datapath definitions: default widths and the parallel row type
// that the systolic array output path hands to downstream stages.
package conv_pkg;

  localparam int DEFAULT_OFMAP_WIDTH = 32;
  localparam int DEFAULT_ARRAY_WIDTH = 3;
  localparam int DEFAULT_FIFO_DEPTH  = 4;

  typedef logic [DEFAULT_OFMAP_WIDTH*DEFAULT_ARRAY_WIDTH-1:0] row_t;

  // Width of a lane index; a single-lane row still needs one select bit.
  function automatic int sel_bits(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/ofmap_row_fifo.sv
// Small synchronous row FIFO with a combinationally visible head entry, so the
// serializer can mux lanes out of the head row without a read-latency cycle.
module ofmap_row_fifo
  import conv_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_OFMAP_WIDTH * DEFAULT_ARRAY_WIDTH,
  parameter int DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_dat,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     head,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 full,
  output logic                 empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [CNT_WIDTH-1:0] count_reg;
  logic [CNT_WIDTH-1:0] count_next;
  logic                 push;
  logic                 pop;

  assign full  = (count_reg == CNT_WIDTH'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign head  = mem[rd_ptr_reg];

  // Full blocks a push even when the head row drains on the same edge.
  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_dat;
  end

endmodule

// File: rtl/ofmap_serializer.sv
// Buffers parallel output-pixel rows and streams them lane 0 first, one word
// per cycle, onto the ofmap valid/ready interface.
module ofmap_serializer
  import conv_pkg::*;
#(
  parameter int OFMAP_WIDTH = DEFAULT_OFMAP_WIDTH,
  parameter int ARRAY_WIDTH = DEFAULT_ARRAY_WIDTH,
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
  parameter int CNT_WIDTH   = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [OFMAP_WIDTH*ARRAY_WIDTH-1:0] row_dat,
  input  logic                               row_vld,
  output logic                               row_rdy,
  output logic [OFMAP_WIDTH-1:0]             ofmap_dat,
  output logic                               ofmap_vld,
  input  logic                               ofmap_rdy,
  output logic [CNT_WIDTH-1:0]               row_count,
  output logic [31:0]                        words_sent
);

  localparam int ROW_W = OFMAP_WIDTH * ARRAY_WIDTH;
  localparam int SEL_W = sel_bits(ARRAY_WIDTH);

  logic [ROW_W-1:0]       head_row;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [OFMAP_WIDTH-1:0] lanes [ARRAY_WIDTH];
  logic [SEL_W-1:0]       sel_reg;
  logic [SEL_W-1:0]       sel_next;
  logic [31:0]            words_sent_reg;
  logic                   xfer;
  logic                   last_lane;

  ofmap_row_fifo #(
    .WIDTH     (ROW_W),
    .DEPTH     (FIFO_DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_row_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (row_vld),
    .wr_dat (row_dat),
    .rd_en  (xfer && last_lane),
    .head   (head_row),
    .count  (row_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  generate
    for (genvar gi = 0; gi < ARRAY_WIDTH; gi++) begin : g_lane
      assign lanes[gi] = head_row[gi*OFMAP_WIDTH +: OFMAP_WIDTH];
    end
  endgenerate

  // Both handshake flags come from FIFO occupancy only, so ofmap_rdy never
  // reaches row_rdy combinationally.
  assign row_rdy   = !fifo_full;
  assign ofmap_vld = !fifo_empty;
  assign xfer      = ofmap_vld && ofmap_rdy;
  assign last_lane = (sel_reg == SEL_W'(ARRAY_WIDTH - 1));
  assign ofmap_dat = ofmap_vld ? lanes[sel_reg] : '0;
  assign words_sent = words_sent_reg;

  always_comb begin
    sel_next = sel_reg;
    if (xfer) begin
      sel_next = last_lane ? '0 : sel_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg        <= '0;
      words_sent_reg <= '0;
    end else begin
      sel_reg <= sel_next;
      if (xfer) words_sent_reg <= words_sent_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_ofmap_serializer.sv
// Scoreboard bench for ofmap_serializer: stimulus queues expected words on row
// acceptance, a negedge monitor pops and compares on every word transfer.
module tb_ofmap_serializer;
  import conv_pkg::*;

  localparam int W  = 32;
  localparam int AW = 3;
  localparam int FD = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  row_t          row_dat = '0;
  logic          row_vld = 1'b0;
  logic          row_rdy;
  logic [W-1:0]  ofmap_dat;
  logic          ofmap_vld;
  logic          ofmap_rdy = 1'b0;
  logic [CW-1:0] row_count;
  logic [31:0]   words_sent;

  ofmap_serializer #(
    .OFMAP_WIDTH (W),
    .ARRAY_WIDTH (AW),
    .FIFO_DEPTH  (FD),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .row_dat    (row_dat),
    .row_vld    (row_vld),
    .row_rdy    (row_rdy),
    .ofmap_dat  (ofmap_dat),
    .ofmap_vld  (ofmap_vld),
    .ofmap_rdy  (ofmap_rdy),
    .row_count  (row_count),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  int          cyc = 0;
  int          xfer_count = 0;
  int          first_xfer_cyc = 0;
  int          last_xfer_cyc = 0;
  bit          arm_first = 1'b0;
  bit          stall_pending = 1'b0;
  logic [31:0] stall_dat = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic row_t make_row(input logic [31:0] l0, input logic [31:0] l1,
                                    input logic [31:0] l2);
    return {l2, l1, l0};
  endfunction

  task automatic queue_row(input row_t r);
    for (int i = 0; i < AW; i++) exp_q.push_back(r[i*W +: W]);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: occupancy model, stall stability, in-order word check.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst_n) begin
      stall_pending = 1'b0;
    end else begin
      chk("vld_model", 32'(ofmap_vld), 32'(exp_q.size() != 0));
      chk("row_rdy_vs_count", 32'(row_rdy), 32'(row_count != CW'(FD)));
      chk("count_bound", 32'(row_count <= CW'(FD)), 32'd1);
      chk("sel_bound", 32'(dut.sel_reg < 2'(AW)), 32'd1);
      if (stall_pending) begin
        chk("stall_vld", 32'(ofmap_vld), 32'd1);
        chk("stall_dat", ofmap_dat, stall_dat);
      end
      if (ofmap_vld && ofmap_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%08h expected none", ofmap_dat);
        end else begin
          e = exp_q.pop_front();
          chk("word", ofmap_dat, e);
        end
        $display("xfer %0d dat=0x%08h", xfer_count, ofmap_dat);
        xfer_count++;
        last_xfer_cyc = cyc;
        if (arm_first) begin
          first_xfer_cyc = cyc;
          arm_first = 1'b0;
        end
      end
      stall_pending = ofmap_vld && !ofmap_rdy;
      stall_dat = ofmap_dat;
    end
  end

  task automatic push_row(input row_t r, input int budget);
    bit ok;
    ok = 1'b0;
    row_vld = 1'b1;
    row_dat = r;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (row_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      queue_row(r);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got row_rdy=0 expected 1 within %0d cycles", budget);
    end
    row_vld = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    bit   acc;
    int   base;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vld", 32'(ofmap_vld), 32'd0);
    chk("reset_row_rdy", 32'(row_rdy), 32'd1);
    chk("reset_dat", ofmap_dat, 32'd0);
    chk("reset_count", 32'(row_count), 32'd0);
    rst_n = 1'b1;

    // Idle after release
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_vld", 32'(ofmap_vld), 32'd0);
      chk("idle_rdy", 32'(row_rdy), 32'd1);
      chk("idle_count", 32'(row_count), 32'd0);
      chk("idle_words", words_sent, 32'd0);
    end

    // Single row streamed with ofmap_rdy high
    @(posedge clk);
    #1;
    ofmap_rdy = 1'b1;
    push_row(make_row(32'h11, 32'h22, 32'h33), 10);
    wait_drain(20);
    chk("single_words", words_sent, 32'd3);
    chk("single_vld_after", 32'(ofmap_vld), 32'd0);

    // Backpressure: head lane held through a 5-cycle stall
    ofmap_rdy = 1'b0;
    push_row(make_row(32'h11, 32'h22, 32'h33), 10);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_hold_dat", ofmap_dat, 32'h11);
    chk("bp_hold_vld", 32'(ofmap_vld), 32'd1);
    chk("bp_hold_words", words_sent, 32'd3);
    ofmap_rdy = 1'b1;
    wait_drain(20);
    chk("bp_words", words_sent, 32'd6);

    // Fill: only FIFO_DEPTH rows accepted while output stalled
    ofmap_rdy = 1'b0;
    n = 0;
    row_vld = 1'b1;
    row_dat = make_row(32'h100, 32'h101, 32'h102);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      acc = row_rdy;
      @(posedge clk);
      if (acc) begin
        queue_row(row_dat);
        n++;
      end
      #1;
      if (acc) row_dat = make_row(32'h100 + 32'(n*3), 32'h101 + 32'(n*3), 32'h102 + 32'(n*3));
    end
    row_vld = 1'b0;
    chk("fill_accepted", 32'(n), 32'd4);
    @(negedge clk);
    chk("fill_row_rdy", 32'(row_rdy), 32'd0);
    chk("fill_count", 32'(row_count), 32'd4);
    @(posedge clk);
    #1;
    ofmap_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("drain_rdy_before", 32'(row_rdy), 32'd0);
    @(negedge clk);
    chk("drain_rdy_after", 32'(row_rdy), 32'd1);
    wait_drain(30);
    chk("fill_words", words_sent, 32'd18);

    // Streaming: 100 rows back to back, 300 gapless words
    base = xfer_count;
    arm_first = 1'b1;
    for (int k = 0; k < 100; k++) begin
      push_row(make_row(32'h1000 + 32'(3*k), 32'h1001 + 32'(3*k), 32'h1002 + 32'(3*k)), 10);
    end
    wait_drain(40);
    chk("stream_count", 32'(xfer_count - base), 32'd300);
    chk("stream_gapless", 32'(last_xfer_cyc - first_xfer_cyc), 32'd299);
    chk("stream_words", words_sent, 32'd318);

    // Mid-stream asynchronous reset
    ofmap_rdy = 1'b0;
    push_row(make_row(32'hA0, 32'hA1, 32'hA2), 10);
    push_row(make_row(32'hB0, 32'hB1, 32'hB2), 10);
    push_row(make_row(32'hC0, 32'hC1, 32'hC2), 10);
    ofmap_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ofmap_rdy = 1'b0;
    chk("mid_words_pre", words_sent, 32'd320);
    chk("mid_dat_pre", ofmap_dat, 32'hA2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(ofmap_vld), 32'd0);
    chk("mid_rst_count", 32'(row_count), 32'd0);
    chk("mid_rst_words", words_sent, 32'd0);
    chk("mid_rst_row_rdy", 32'(row_rdy), 32'd1);
    chk("mid_rst_dat", ofmap_dat, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ofmap_rdy = 1'b1;
    push_row(make_row(32'hD0, 32'hD1, 32'hD2), 10);
    wait_drain(20);
    chk("post_rst_words", words_sent, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
